// File: rtl/ma_xif_pkg.sv
// Shared types for the CV-X-IF issue queue: per-entry state, entry header, default opcode.
package ma_xif_pkg;

  localparam logic [6:0] OPCODE_DEFAULT = 7'h2B;

  typedef enum logic [2:0] {
    ST_FREE,
    ST_WAIT_OPS,
    ST_WAIT_COMMIT,
    ST_READY_NOOPS,
    ST_READY,
    ST_KILLED
  } entry_state_e;

  typedef struct packed {
    entry_state_e state;
    logic [31:0]  instr;
  } entry_hdr_t;

  function automatic logic is_live(input entry_state_e s);
    return (s != ST_FREE) && (s != ST_KILLED);
  endfunction

endpackage

// File: rtl/ma_iq_entry.sv
// One issue-queue slot: tracks operand/commit progress of a single offloaded instruction.
// Exposes kill_evt_o only when MA_IQ_KILL_COUNTER_EN is defined.
module ma_iq_entry
  import ma_xif_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int XLEN     = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_i,
  input  logic [31:0]         alloc_instr_i,
  input  logic [ID_WIDTH-1:0] alloc_id_i,
  input  logic                reg_valid_i,
  input  logic [ID_WIDTH-1:0] reg_id_i,
  input  logic [XLEN-1:0]     rs1_i,
  input  logic [XLEN-1:0]     rs2_i,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  input  logic                free_i,
  output entry_hdr_t          hdr_o,
  output logic [ID_WIDTH-1:0] id_o,
  output logic [XLEN-1:0]     rs1_o,
`ifdef MA_IQ_KILL_COUNTER_EN
  output logic                kill_evt_o,
`endif
  output logic [XLEN-1:0]     rs2_o
);

  entry_state_e        state_q, state_d, base_st;
  logic [31:0]         instr_q;
  logic [ID_WIDTH-1:0] id_q, eff_id;
  logic [XLEN-1:0]     rs1_q, rs2_q;
  logic                reg_hit, cmt_hit, has_ops, committed;

  // A slot being allocated this cycle already answers to the incoming id.
  always_comb begin
    base_st   = alloc_i ? ST_WAIT_OPS : state_q;
    eff_id    = alloc_i ? alloc_id_i : id_q;
    reg_hit   = reg_valid_i && (eff_id == reg_id_i) &&
                ((base_st == ST_WAIT_OPS) || (base_st == ST_READY_NOOPS));
    cmt_hit   = commit_valid_i && (eff_id == commit_id_i) && is_live(base_st);
    has_ops   = reg_hit || (base_st == ST_WAIT_COMMIT) || (base_st == ST_READY);
    committed = cmt_hit || (base_st == ST_READY_NOOPS) || (base_st == ST_READY);
    state_d   = base_st;
    if (free_i) begin
      state_d = ST_FREE;
    end else if (cmt_hit && commit_kill_i) begin
      state_d = ST_KILLED;
    end else if (is_live(base_st)) begin
      if (has_ops && committed) state_d = ST_READY;
      else if (committed)       state_d = ST_READY_NOOPS;
      else if (has_ops)         state_d = ST_WAIT_COMMIT;
      else                      state_d = ST_WAIT_OPS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FREE;
      instr_q <= '0;
      id_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      state_q <= state_d;
      if (alloc_i) begin
        instr_q <= alloc_instr_i;
        id_q    <= alloc_id_i;
      end
      if (reg_hit && !free_i) begin
        rs1_q <= rs1_i;
        rs2_q <= rs2_i;
      end
    end
  end

  assign hdr_o.state = state_q;
  assign hdr_o.instr = instr_q;
  assign id_o        = id_q;
  assign rs1_o       = rs1_q;
  assign rs2_o       = rs2_q;
`ifdef MA_IQ_KILL_COUNTER_EN
  assign kill_evt_o  = !free_i && cmt_hit && commit_kill_i;
`endif

endmodule

// File: rtl/ma_xif_issue_queue.sv
// In-order CV-X-IF issue queue feeding an accelerator; killed entries drain silently.
// Define MA_IQ_KILL_COUNTER_EN to enable the saturating killed-instruction counter.
module ma_xif_issue_queue
  import ma_xif_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter int         ID_WIDTH = 4,
  parameter int         XLEN     = 64,
  parameter logic [6:0] OPCODE   = OPCODE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [31:0]                issue_instr_i,
  input  logic [ID_WIDTH-1:0]        issue_id_i,
  output logic                       issue_accept_o,
  input  logic                       register_valid_i,
  output logic                       register_ready_o,
  input  logic [ID_WIDTH-1:0]        register_id_i,
  input  logic [XLEN-1:0]            rs1_i,
  input  logic [XLEN-1:0]            rs2_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_instr_o,
  output logic [ID_WIDTH-1:0]        out_id_o,
  output logic [XLEN-1:0]            out_rs1_o,
  output logic [XLEN-1:0]            out_rs2_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic [15:0]                killed_count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;

  logic [OCC_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       head_idx, tail_idx;
  logic                full, enq, deq;
  entry_state_e        head_st;
  entry_hdr_t          hdr     [DEPTH];
  logic [ID_WIDTH-1:0] id_arr  [DEPTH];
  logic [XLEN-1:0]     rs1_arr [DEPTH];
  logic [XLEN-1:0]     rs2_arr [DEPTH];
  logic [DEPTH-1:0]    alloc_vec, free_vec;
`ifdef MA_IQ_KILL_COUNTER_EN
  logic [DEPTH-1:0]    kill_vec;
`endif

  assign head_idx = rd_ptr_q[AW-1:0];
  assign tail_idx = wr_ptr_q[AW-1:0];
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (head_idx == tail_idx);

  assign issue_accept_o   = (issue_instr_i[6:0] == OPCODE);
  assign issue_ready_o    = !full;
  assign register_ready_o = 1'b1;
  assign enq              = issue_valid_i && !full && issue_accept_o;

  assign head_st     = hdr[head_idx].state;
  assign out_valid_o = (head_st == ST_READY);
  assign deq         = (out_valid_o && out_ready_i) || (head_st == ST_KILLED);
  assign out_instr_o = hdr[head_idx].instr;
  assign out_id_o    = id_arr[head_idx];
  assign out_rs1_o   = rs1_arr[head_idx];
  assign out_rs2_o   = rs2_arr[head_idx];
  assign occupancy_o = wr_ptr_q - rd_ptr_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign alloc_vec[g] = enq && (tail_idx == AW'(g));
    assign free_vec[g]  = deq && (head_idx == AW'(g));

    ma_iq_entry #(
      .ID_WIDTH (ID_WIDTH),
      .XLEN     (XLEN)
    ) u_entry (
      .clk            (clk),
      .rst_n          (rst_n),
      .alloc_i        (alloc_vec[g]),
      .alloc_instr_i  (issue_instr_i),
      .alloc_id_i     (issue_id_i),
      .reg_valid_i    (register_valid_i),
      .reg_id_i       (register_id_i),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .commit_valid_i (commit_valid_i),
      .commit_id_i    (commit_id_i),
      .commit_kill_i  (commit_kill_i),
      .free_i         (free_vec[g]),
      .hdr_o          (hdr[g]),
      .id_o           (id_arr[g]),
      .rs1_o          (rs1_arr[g]),
`ifdef MA_IQ_KILL_COUNTER_EN
      .kill_evt_o     (kill_vec[g]),
`endif
      .rs2_o          (rs2_arr[g])
    );
  end

  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + OCC_W'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + OCC_W'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef MA_IQ_KILL_COUNTER_EN
  logic [15:0]      kcnt_q, kcnt_d;
  logic [OCC_W-1:0] kill_num;
  logic [16:0]      ksum;

  // Several slots can be killed in one cycle if ids alias, so sum them.
  always_comb begin
    kill_num = '0;
    for (int k = 0; k < DEPTH; k++) kill_num = kill_num + OCC_W'(kill_vec[k]);
    ksum   = {1'b0, kcnt_q} + 17'(kill_num);
    kcnt_d = ksum[16] ? 16'hFFFF : ksum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kcnt_q <= '0;
    else        kcnt_q <= kcnt_d;
  end

  assign killed_count_o = kcnt_q;
`else
  assign killed_count_o = '0;
`endif

endmodule

// File: doc/ma_xif_issue_queue.md
MA_XIF_ISSUE_QUEUE -- requirements
Module: ma_xif_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter ID_WIDTH, default 4, CV-X-IF instruction id width.
REQ-003 SHALL have parameter XLEN, default 64, operand width.
REQ-004 SHALL have parameter OPCODE, default 7'h2B, accepted major opcode.
REQ-005 SHALL have ports as listed:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- issue_valid_i / issue_ready_o  in/out  1  issue handshake.
- issue_instr_i  in  32  offloaded instruction.
- issue_id_i  in  ID_WIDTH  instruction id.
- issue_accept_o  out  1  opcode match.
- register_valid_i / register_ready_o  in/out  1  operand handshake.
- register_id_i  in  ID_WIDTH  operand id.
- rs1_i, rs2_i  in  XLEN  operands.
- commit_valid_i  in  1  commit strobe (no ready).
- commit_id_i  in  ID_WIDTH  id; commit_kill_i  in  1  kill flag.
- out_valid_o / out_ready_i  out/in  1  dispatch to accelerator.
- out_instr_o  out  32; out_id_o  out  ID_WIDTH; out_rs1_o, out_rs2_o  out  XLEN.
- occupancy_o  out  $clog2(DEPTH)+1  live entries.
- killed_count_o  out  16  killed-instruction counter.

Function
REQ-006 SHALL drive issue_accept_o = (issue_instr_i[6:0]==OPCODE), combinational.
REQ-007 SHALL drive issue_ready_o = !full; no same-cycle enqueue bypass when full.
REQ-008 SHALL allocate tail entry only on issue handshake with accept=1; rejected handshakes allocate nothing.
REQ-009 SHALL keep a per-entry FSM: FREE -> WAIT_OPS (issue) -> WAIT_COMMIT (operands) -> READY (commit, kill=0); any live state -> KILLED (commit, kill=1).
REQ-010 SHALL also allow WAIT_OPS -> READY_NOOPS on commit-before-operands, then READY on operands.
REQ-011 SHALL hold register_ready_o = 1; register/commit for an id matching no live entry SHALL be ignored.
REQ-012 SHALL, for a commit whose id equals a same-cycle accepted issue id, apply it to the new entry.
REQ-013 SHALL apply same-cycle register and commit to one entry together.
REQ-014 SHALL retire strictly in order from head; out_valid_o = head in READY; fields are head registers.
REQ-015 SHALL free head on out_valid_o && out_ready_i; KILLED head SHALL free silently in one cycle, no out_valid_o.
REQ-016 SHALL achieve out_valid_o one cycle after the later of operand capture and commit.
REQ-017 SHALL hold out_* stable while out_valid_o && !out_ready_i.
REQ-018 SHALL wrap head/tail pointers modulo DEPTH; full/empty via extra pointer bit.
REQ-019 SHALL update occupancy_o with simultaneous enqueue and retire netting to zero change.

Reset
REQ-020 SHALL, on rst_n low (async, including mid-operation), set all entries FREE, pointers 0, and all outputs 0 except issue_ready_o=1, register_ready_o=1.

Configuration
REQ-021 SHALL, with MA_IQ_KILL_COUNTER_EN defined, increment killed_count_o per entry entering KILLED, saturating at 16'hFFFF; without it, tie killed_count_o to 0 and omit the counter.

Structure
REQ-022 SHALL place entry-state enum, entry struct, and OPCODE default in package ma_xif_pkg.
REQ-023 SHALL implement per-slot FSM as sub-module ma_iq_entry, instanced DEPTH times.

Verification
REQ-024 Issue instr opcode 0x2B id 3, register id 3 rs1=0x11 rs2=0x22, commit id 3 kill=0 -> out_valid_o one cycle later, out_rs1_o=0x11, out_id_o=3.
REQ-025 Issue ids 0..3 (DEPTH=4) -> issue_ready_o=0, occupancy_o=4; retire one -> issue_ready_o=1 next cycle.
REQ-026 Issue ids 1,2; commit id 1 kill=1, id 2 kill=0 with operands -> only id 2 dispatched; killed_count_o=1 (macro on), 0 (off).
REQ-027 Issue opcode 0x33 -> issue_accept_o=0, occupancy_o unchanged.
REQ-028 Commit id 5 before register id 5 -> out_valid_o one cycle after operand capture; out_ready_i=0 for 3 cycles holds outputs stable.
REQ-029 Assert rst_n low with 3 live entries -> occupancy_o=0, out_valid_o=0 immediately.
